fg_sweep_ctrl: RTL and testbench

//  Configuration sequencer for the func_gen datapath. It accepts one waveform configuration

---
 rtl/fg_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_fg_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_sweep_ctrl.sv
// fg_sweep_ctrl: configuration sequencer for func_gen.
// Holds one shadowed waveform configuration. On start it either parks func_gen
// at a fixed set_count or sweeps set_count from start to stop, one clamped
// step per dwell period.
module fg_sweep_ctrl #(
    parameter int CNT_W   = 32,
    parameter int DWELL_W = 32,
    parameter int DUTY_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_sig_type,
    input  logic [DUTY_W-1:0]  cfg_duty,
    input  logic               cfg_sweep_en,
    input  logic [CNT_W-1:0]   cfg_start_count,
    input  logic [CNT_W-1:0]   cfg_stop_count,
    input  logic [CNT_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               abort,
    output logic [CNT_W-1:0]   set_count,
    output logic [1:0]         sig_type,
    output logic [DUTY_W-1:0]  duty_cycle,
    output logic               fg_rst_n,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD, S_DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]         sh_type;
    logic [DUTY_W-1:0]  sh_duty;
    logic               sh_sweep;
    logic [CNT_W-1:0]   sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic               loaded;

    logic               dir_up;
    logic [DWELL_W-1:0] dwell_cnt;

    logic               cfg_acc;
    logic [DWELL_W-1:0] dwell_last;
    logic               dwell_end;
    logic               at_stop;
    logic [CNT_W-1:0]   eff_step;
    logic [CNT_W:0]     nxt_up, nxt_dn;
    logic [CNT_W-1:0]   step_val;

    assign cfg_acc    = cfg_valid && cfg_ready;
    // dwell of 0 behaves as 1: a step every cycle
    assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - DWELL_W'(1);
    assign dwell_end  = (dwell_cnt == dwell_last);
    assign at_stop    = (set_count == sh_stop);
    assign eff_step   = (sh_step == '0) ? CNT_W'(1) : sh_step;
    assign nxt_up     = {1'b0, set_count} + {1'b0, eff_step};
    assign nxt_dn     = {1'b0, set_count} - {1'b0, eff_step};

    // next sweep value; the extra bit catches wrap past max/0, which clamps to stop
    always_comb begin
        step_val = sh_stop;
        if (dir_up) begin
            if (!nxt_up[CNT_W] && (nxt_up[CNT_W-1:0] <= sh_stop))
                step_val = nxt_up[CNT_W-1:0];
        end else begin
            if (!nxt_dn[CNT_W] && (nxt_dn[CNT_W-1:0] >= sh_stop))
                step_val = nxt_dn[CNT_W-1:0];
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic; abort overrides everything outside IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && (loaded || cfg_acc)) state_nxt = S_LOAD;
            S_LOAD: state_nxt = sh_sweep ? S_RUN : S_HOLD;
            S_RUN:  if (dwell_end && at_stop) state_nxt = S_DONE;
            S_HOLD: state_nxt = S_HOLD;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    // state-decoded outputs
    always_comb begin
        cfg_ready = (state == S_IDLE);
        busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_HOLD);
        done      = (state == S_DONE);
    end

    // shadow registers and func_gen drive registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_type    <= '0;
            sh_duty    <= '0;
            sh_sweep   <= 1'b0;
            sh_start   <= '0;
            sh_stop    <= '0;
            sh_step    <= '0;
            sh_dwell   <= '0;
            loaded     <= 1'b0;
            dir_up     <= 1'b0;
            dwell_cnt  <= '0;
            set_count  <= '0;
            sig_type   <= '0;
            duty_cycle <= '0;
            fg_rst_n   <= 1'b0;
        end else begin
            if (cfg_acc) begin
                sh_type  <= cfg_sig_type;
                sh_duty  <= cfg_duty;
                sh_sweep <= cfg_sweep_en;
                sh_start <= cfg_start_count;
                sh_stop  <= cfg_stop_count;
                sh_step  <= cfg_step;
                sh_dwell <= cfg_dwell;
                loaded   <= 1'b1;
            end
            case (state)
                // entering LOAD holds func_gen in reset for that one cycle
                S_IDLE: if (state_nxt == S_LOAD) fg_rst_n <= 1'b0;
                S_LOAD: if (!abort) begin
                    set_count  <= sh_start;
                    sig_type   <= sh_type;
                    duty_cycle <= sh_duty;
                    dwell_cnt  <= '0;
                    dir_up     <= (sh_start <= sh_stop);
                    fg_rst_n   <= 1'b1;
                end
                S_RUN: if (!abort) begin
                    if (dwell_end) begin
                        dwell_cnt <= '0;
                        if (!at_stop) set_count <= step_val;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: ;
            endcase
            if (abort && (state != S_IDLE)) fg_rst_n <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// Bench for fg_sweep_ctrl. Stimulus pushes the expected output events
// (set_count / fg_rst_n changes and done pulses, with cycle spacing) into a
// queue; the monitor pops one per observed event and compares.
module tb_fg_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready;
    logic [1:0]  cfg_sig_type;
    logic [7:0]  cfg_duty;
    logic        cfg_sweep_en;
    logic [31:0] cfg_start_count, cfg_stop_count, cfg_step, cfg_dwell;
    logic        start, abort;
    logic [31:0] set_count;
    logic [1:0]  sig_type;
    logic [7:0]  duty_cycle;
    logic        fg_rst_n, busy, done;

    fg_sweep_ctrl #(.CNT_W(32), .DWELL_W(32), .DUTY_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_sig_type(cfg_sig_type), .cfg_duty(cfg_duty), .cfg_sweep_en(cfg_sweep_en),
        .cfg_start_count(cfg_start_count), .cfg_stop_count(cfg_stop_count),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .start(start), .abort(abort),
        .set_count(set_count), .sig_type(sig_type), .duty_cycle(duty_cycle),
        .fg_rst_n(fg_rst_n), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cnt;
        logic        rn;
        logic        dn;
        logic [15:0] gap;   // negedges since previous event, 0 = don't care
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic expect_ev(input logic [31:0] c, input logic rn, input logic dn, input int g);
        ev_t e;
        e.cnt = c; e.rn = rn; e.dn = dn; e.gap = 16'(g);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor: an event is any set_count or fg_rst_n change, or done high
    logic [31:0] p_cnt = '0;
    logic        p_rn  = 1'b0;
    int          gap   = 0;
    always @(negedge clk) begin
        ev_t e;
        gap++;
        if (set_count !== p_cnt || fg_rst_n !== p_rn || done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got cnt=%0h rst_n=%0b done=%0b, expected no event",
                         set_count, fg_rst_n, done);
            end else begin
                e = exp_q.pop_front();
                if ({set_count, fg_rst_n, done} !== {e.cnt, e.rn, e.dn} ||
                    (e.gap != 0 && int'(e.gap) != gap)) begin
                    n_bad++;
                    $display("FAIL event: got cnt=%0h rst_n=%0b done=%0b gap=%0d, expected cnt=%0h rst_n=%0b done=%0b gap=%0d",
                             set_count, fg_rst_n, done, gap, e.cnt, e.rn, e.dn, e.gap);
                end
            end
            gap   = 0;
            p_cnt = set_count;
            p_rn  = fg_rst_n;
        end
    end

    task automatic send_cfg(input logic [1:0] t, input logic [7:0] d, input logic sw,
                            input logic [31:0] s, input logic [31:0] p, input logic [31:0] st,
                            input logic [31:0] dw, input logic with_start);
        @(negedge clk);
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_sig_type = t; cfg_duty = d; cfg_sweep_en = sw;
        cfg_start_count = s; cfg_stop_count = p; cfg_step = st; cfg_dwell = dw;
        cfg_valid = 1'b1; start = with_start;
        @(negedge clk);
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d events pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_cnt(input string name, input logic [31:0] v);
        int i;
        i = 0;
        while (set_count !== v && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk(name, set_count, v);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_sig_type = '0; cfg_duty = '0; cfg_sweep_en = 1'b0;
        cfg_start_count = '0; cfg_stop_count = '0; cfg_step = '0; cfg_dwell = '0;
        #12;
        chk("rst_set_count", set_count, 32'd0);
        chk("rst_sig_type",  {30'd0, sig_type}, 32'd0);
        chk("rst_duty",      {24'd0, duty_cycle}, 32'd0);
        chk("rst_fg_rst_n",  {31'd0, fg_rst_n}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_done",      {31'd0, done}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // start with nothing loaded is ignored
        pulse_start();
        repeat (3) @(negedge clk);
        chk("unloaded_start_busy", {31'd0, busy}, 32'd0);

        // fixed mode, SQUARE at 9
        expect_ev(32'd9, 1'b1, 1'b0, 0);
        send_cfg(2'd2, 8'h40, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0, 1'b0);
        pulse_start();
        chk("load_fg_rst_n", {31'd0, fg_rst_n}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("hold_sig_type", {30'd0, sig_type}, 32'd2);
        chk("hold_duty", {24'd0, duty_cycle}, 32'h40);
        repeat (5) @(negedge clk);
        chk("hold_set_count", set_count, 32'd9);
        chk("hold_busy", {31'd0, busy}, 32'd1);
        chk("hold_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        expect_ev(32'd9, 1'b0, 1'b0, 0);
        pulse_abort();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_sig_type", {30'd0, sig_type}, 32'd2);
        drain("fixed", 10);

        // sweep up 10 -> 20, step 4, dwell 5
        expect_ev(32'd10, 1'b1, 1'b0, 0);
        expect_ev(32'd14, 1'b1, 1'b0, 5);
        expect_ev(32'd18, 1'b1, 1'b0, 5);
        expect_ev(32'd20, 1'b1, 1'b0, 5);
        expect_ev(32'd20, 1'b1, 1'b1, 5);
        send_cfg(2'd0, 8'h00, 1'b1, 32'd10, 32'd20, 32'd4, 32'd5, 1'b0);
        pulse_start();
        drain("sweep_up", 100);
        repeat (3) @(negedge clk);
        chk("up_idle_busy", {31'd0, busy}, 32'd0);
        chk("up_final_count", set_count, 32'd20);
        chk("up_keeps_running", {31'd0, fg_rst_n}, 32'd1);

        // sweep down 100 -> 90, step 0 (as 1), dwell 0 (as 1)
        expect_ev(32'd20, 1'b0, 1'b0, 0);
        for (int v = 100; v >= 90; v--) expect_ev(32'(v), 1'b1, 1'b0, 1);
        expect_ev(32'd90, 1'b1, 1'b1, 1);
        send_cfg(2'd1, 8'h00, 1'b1, 32'd100, 32'd90, 32'd0, 32'd0, 1'b0);
        pulse_start();
        drain("sweep_down", 100);
        repeat (3) @(negedge clk);
        chk("down_idle_busy", {31'd0, busy}, 32'd0);

        // overflow clamps to stop, no wrap
        expect_ev(32'd90, 1'b0, 1'b0, 0);
        expect_ev(32'hFFFF_FFF0, 1'b1, 1'b0, 1);
        expect_ev(32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        expect_ev(32'hFFFF_FFFF, 1'b1, 1'b1, 2);
        send_cfg(2'd0, 8'h00, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd2, 1'b0);
        pulse_start();
        drain("overflow", 100);
        repeat (3) @(negedge clk);

        // abort mid-dwell, then restart from the shadow configuration
        expect_ev(32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        expect_ev(32'd10, 1'b1, 1'b0, 1);
        expect_ev(32'd14, 1'b1, 1'b0, 5);
        send_cfg(2'd2, 8'h00, 1'b1, 32'd10, 32'd20, 32'd4, 32'd5, 1'b0);
        pulse_start();
        wait_cnt("abort_reach14", 32'd14);
        @(negedge clk);
        expect_ev(32'd14, 1'b0, 1'b0, 3);
        pulse_abort();
        repeat (4) @(negedge clk);
        chk("abort_mid_busy", {31'd0, busy}, 32'd0);
        chk("abort_mid_count", set_count, 32'd14);
        chk("abort_mid_rst_n", {31'd0, fg_rst_n}, 32'd0);
        drain("abort", 10);
        expect_ev(32'd10, 1'b1, 1'b0, 0);
        expect_ev(32'd14, 1'b1, 1'b0, 5);
        expect_ev(32'd18, 1'b1, 1'b0, 5);
        expect_ev(32'd20, 1'b1, 1'b0, 5);
        expect_ev(32'd20, 1'b1, 1'b1, 5);
        pulse_start();
        drain("restart", 100);
        repeat (3) @(negedge clk);

        // cfg transfer and start in the same cycle use the new values
        expect_ev(32'd20, 1'b0, 1'b0, 0);
        expect_ev(32'd55, 1'b1, 1'b0, 1);
        send_cfg(2'd3, 8'd77, 1'b0, 32'd55, 32'd0, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("same_cycle_count", set_count, 32'd55);
        chk("same_cycle_type", {30'd0, sig_type}, 32'd3);
        chk("same_cycle_duty", {24'd0, duty_cycle}, 32'd77);
        expect_ev(32'd55, 1'b0, 1'b0, 0);
        pulse_abort();
        drain("same_cycle", 10);

        // asynchronous reset mid-RUN
        expect_ev(32'd1, 1'b1, 1'b0, 0);
        expect_ev(32'd2, 1'b1, 1'b0, 3);
        send_cfg(2'd1, 8'd9, 1'b1, 32'd1, 32'd1000, 32'd1, 32'd3, 1'b0);
        pulse_start();
        wait_cnt("rst_reach2", 32'd2);
        expect_ev(32'd0, 1'b0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", set_count, 32'd0);
        chk("async_rst_type", {30'd0, sig_type}, 32'd0);
        chk("async_rst_duty", {24'd0, duty_cycle}, 32'd0);
        chk("async_rst_rst_n", {31'd0, fg_rst_n}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("rst_clears_loaded", {31'd0, busy}, 32'd0);
        drain("final", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
